somamulti_arbiter: RTL

Two-requester scheduler that shares a single `somaMulti` add/multiply datapath. It accepts operand/opcode requests from two clients and grants one operation at a time. It drives the shared unit from registered operands and returns a registered result with a per-client completion pulse. It sits between the client blocks and the one `somaMulti` instance, so clients never drive `A`/`B`/`sel` directly.

---
 rtl/somamulti_arbiter_pkg.sv | 9 +
 rtl/somamulti_arbiter_somamulti.sv | 13 +
 rtl/somamulti_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/somamulti_arbiter_pkg.sv
// somamulti_pkg: shared widths, opcode encoding and arbiter FSM state constants
package somamulti_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic SEL_SOMA = 1'b0;
  localparam logic SEL_MULT = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/somamulti_arbiter_somamulti.sv
// somaMulti: combinational sum/product unit, result truncated to WIDTH bits
module somaMulti
  import somamulti_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = (sel == SEL_MULT) ? A * B : A + B;
endmodule

// File: rtl/somamulti_arbiter.sv
// somamulti_arbiter: two-client IDLE/EXEC/DONE scheduler for one shared somaMulti
// SOMAMULTI_ARB_FIXED_PRIO_EN: client 0 always wins ties (no round-robin state)
module somamulti_arbiter
  import somamulti_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             sel0,
  input  logic             sel1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       ack,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] saida,
  output logic             busy
);
  logic [1:0]       state;
  logic [WIDTH-1:0] op_a, op_b, result_comb;
  logic             op_sel, owner, winner;
`ifdef SOMAMULTI_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  logic last_grant;
  assign winner = (req0 && req1) ? ~last_grant : req1;
`endif
  somaMulti #(.WIDTH(WIDTH)) u_soma (.A(op_a), .B(op_b), .sel(op_sel), .y(result_comb));
  assign ack  = (state == ST_EXEC) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign done = (state == ST_DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != ST_IDLE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      saida  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 1'b0;
      owner  <= 1'b0;
`ifndef SOMAMULTI_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else if (state == ST_IDLE && (req0 || req1)) begin
      state  <= ST_EXEC;
      owner  <= winner;
      op_a   <= winner ? a1 : a0;
      op_b   <= winner ? b1 : b0;
      op_sel <= winner ? sel1 : sel0;
`ifndef SOMAMULTI_ARB_FIXED_PRIO_EN
      last_grant <= winner;
`endif
    end else if (state == ST_EXEC) begin
      saida <= result_comb;
      state <= ST_DONE;
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end
endmodule
